// File: rtl/alu_tx_sequencer.sv
// rtl/alu_tx_sequencer.sv - ALU operand loader and decimal ASCII result printer
// Loads operands while idle, then prints each ALU result as decimal text into a TX FIFO.
module alu_tx_sequencer #(
  parameter int NBIT   = 8,
  parameter int SIGNED = 1,
  parameter int CRLF   = 1
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [7:0]      data_in,
  input  logic [2:0]      SEL,
  input  logic            FIN,
  input  logic [NBIT-1:0] alu_res,
  input  logic            FIFO_full,
  output logic [NBIT-1:0] ALU_A,
  output logic [NBIT-1:0] ALU_B,
  output logic [7:0]      ALU_OP,
  output logic [7:0]      data_out,
  output logic            WR_FIFO,
  output logic            BUSY,
  output logic            OVR,
  output logic [2:0]      STATE
);

  localparam int RW = (NBIT < 8) ? 8 : NBIT;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_DIV     = 3'd2,
    S_SIGN    = 3'd3,
    S_DIGIT   = 3'd4,
    S_CR      = 3'd5,
    S_LF      = 3'd6
  } state_t;

  state_t          state_q;
  logic [NBIT-1:0] a_q, b_q;
  logic [7:0]      op_q, dout_q;
  logic [RW-1:0]   rem_q;
  logic [3:0]      h_q, t_q, u_q;
  logic [1:0]      pos_q;
  logic            neg_q, ovr_q;

  logic            neg_d;
  logic [NBIT-1:0] mag_d;
  logic [1:0]      lead_pos_d, next_pos_d;

  // pos selects the digit being printed: 0 = hundreds, 1 = tens, 2 = units.
  function automatic logic [1:0] first_pos(input logic [3:0] h, input logic [3:0] t);
    logic [1:0] p;
    if (h != 4'd0)      p = 2'd0;
    else if (t != 4'd0) p = 2'd1;
    else                p = 2'd2;
    return p;
  endfunction

  function automatic logic [7:0] pos_char(input logic [1:0] p, input logic [3:0] h,
                                          input logic [3:0] t, input logic [3:0] u);
    logic [3:0] d;
    case (p)
      2'd0:    d = h;
      2'd1:    d = t;
      default: d = u;
    endcase
    return 8'h30 + {4'h0, d};
  endfunction

  assign neg_d      = (SIGNED != 0) && alu_res[NBIT-1];
  assign mag_d      = neg_d ? ({NBIT{1'b0}} - alu_res) : alu_res;
  assign lead_pos_d = first_pos(h_q, t_q);
  assign next_pos_d = pos_q + 2'd1;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 8'h20;
      dout_q  <= 8'h00;
      rem_q   <= '0;
      h_q     <= 4'd0;
      t_q     <= 4'd0;
      u_q     <= 4'd0;
      pos_q   <= 2'd0;
      neg_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ovr_q <= FIN && (state_q != S_IDLE);

      if (state_q == S_IDLE) begin
        case (SEL)
          3'b001:  a_q  <= NBIT'(data_in);
          3'b010:  b_q  <= NBIT'(data_in);
          3'b100:  op_q <= data_in;
          default: ;
        endcase
      end

      case (state_q)
        S_IDLE: begin
          if (FIN) state_q <= S_CAPTURE;
        end
        S_CAPTURE: begin
          rem_q   <= RW'(mag_d);
          neg_q   <= neg_d;
          h_q     <= 4'd0;
          t_q     <= 4'd0;
          state_q <= S_DIV;
        end
        S_DIV: begin
          if (rem_q >= RW'(100)) begin
            rem_q <= rem_q - RW'(100);
            h_q   <= h_q + 4'd1;
          end else if (rem_q >= RW'(10)) begin
            rem_q <= rem_q - RW'(10);
            t_q   <= t_q + 4'd1;
          end else begin
            u_q     <= rem_q[3:0];
            pos_q   <= lead_pos_d;
            state_q <= neg_q ? S_SIGN : S_DIGIT;
            dout_q  <= neg_q ? 8'h2D : pos_char(lead_pos_d, h_q, t_q, rem_q[3:0]);
          end
        end
        // Emission states only advance on a cycle where the FIFO accepted the character.
        S_SIGN: begin
          if (!FIFO_full) begin
            state_q <= S_DIGIT;
            dout_q  <= pos_char(pos_q, h_q, t_q, u_q);
          end
        end
        S_DIGIT: begin
          if (!FIFO_full) begin
            if (pos_q == 2'd2) begin
              if (CRLF != 0) begin
                state_q <= S_CR;
                dout_q  <= 8'h0D;
              end else begin
                state_q <= S_IDLE;
              end
            end else begin
              pos_q  <= next_pos_d;
              dout_q <= pos_char(next_pos_d, h_q, t_q, u_q);
            end
          end
        end
        S_CR: begin
          if (!FIFO_full) begin
            state_q <= S_LF;
            dout_q  <= 8'h0A;
          end
        end
        S_LF: begin
          if (!FIFO_full) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ALU_A    = a_q;
  assign ALU_B    = b_q;
  assign ALU_OP   = op_q;
  assign data_out = dout_q;
  assign WR_FIFO  = (state_q == S_SIGN || state_q == S_DIGIT ||
                     state_q == S_CR   || state_q == S_LF) && !FIFO_full;
  assign BUSY     = (state_q != S_IDLE);
  assign OVR      = ovr_q;
  assign STATE    = state_q;

endmodule

// File: tb/tb_alu_tx_sequencer.sv
// tb/tb_alu_tx_sequencer.sv - scoreboard bench for alu_tx_sequencer
// Expected text is derived from the decimal value of each result, timing from a per-cycle FIFO-full map.
module tb_alu_tx_sequencer;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic [2:0] SEL = 3'b000;
  logic       FIN = 1'b0;
  logic       FIN1 = 1'b0;
  logic [7:0] alu_res = 8'h00;
  logic       FIFO_full = 1'b0;

  logic [7:0] ALU_A, ALU_B, ALU_OP, data_out;
  logic       WR_FIFO, BUSY, OVR;
  logic [2:0] STATE;
  logic [7:0] a1, b1, op1, dout1;
  logic       wr1, busy1, ovr1;
  logic [2:0] state1;

  alu_tx_sequencer #(.NBIT(8), .SIGNED(1), .CRLF(1)) u_dut (
    .CLK(CLK), .RESET(RESET), .data_in(data_in), .SEL(SEL), .FIN(FIN),
    .alu_res(alu_res), .FIFO_full(FIFO_full),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_OP(ALU_OP), .data_out(data_out),
    .WR_FIFO(WR_FIFO), .BUSY(BUSY), .OVR(OVR), .STATE(STATE)
  );

  alu_tx_sequencer #(.NBIT(8), .SIGNED(0), .CRLF(1)) u_uns (
    .CLK(CLK), .RESET(RESET), .data_in(data_in), .SEL(SEL), .FIN(FIN1),
    .alu_res(alu_res), .FIFO_full(FIFO_full),
    .ALU_A(a1), .ALU_B(b1), .ALU_OP(op1), .data_out(dout1),
    .WR_FIFO(wr1), .BUSY(busy1), .OVR(ovr1), .STATE(state1)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] ch;
    int         cyc;
    bit         last;
  } exp_t;

  exp_t       q0[$];
  exp_t       q1[$];
  int         ovr_q[$];
  int         idle_chk0 = -1;
  int         idle_chk1 = -1;
  int         n_cmp = 0;
  int         n_fail = 0;
  bit         full_at [0:16383];
  logic [7:0] exp_a = 8'h00, exp_b = 8'h00, exp_op = 8'h20;
  logic [2:0] sels [0:4] = '{3'b001, 3'b010, 3'b100, 3'b000, 3'b110};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: decimal text of the value, then per-character write cycles given the full map.
  task automatic push_expect(input logic [7:0] v, input bit sgn, input int tc, input bit inst,
                             output int first, output int last);
    logic [7:0] txt[$];
    int mag, h, t, u, e;
    bit neg;
    exp_t it;
    neg = sgn && v[7];
    mag = neg ? 256 - int'({24'd0, v}) : int'({24'd0, v});
    h = mag / 100;
    t = (mag / 10) % 10;
    u = mag % 10;
    if (neg) txt.push_back(8'h2D);
    if (h != 0) txt.push_back(8'h30 + 8'(h));
    if (h != 0 || t != 0) txt.push_back(8'h30 + 8'(t));
    txt.push_back(8'h30 + 8'(u));
    txt.push_back(8'h0D);
    txt.push_back(8'h0A);
    e = tc + 3 + h + t;
    first = -1;
    foreach (txt[i]) begin
      while (full_at[e]) e++;
      if (first < 0) first = e;
      it.ch = txt[i];
      it.cyc = e;
      it.last = (i == txt.size() - 1);
      if (inst) q1.push_back(it);
      else q0.push_back(it);
      e++;
    end
    last = e - 1;
  endtask

  initial begin
    forever begin
      @(posedge CLK);
      #1;
      FIFO_full = full_at[cyc];
    end
  end

  exp_t m0_e;
  always @(negedge CLK) begin
    if (RESET) begin
      if (q0.size() > 0 && q0[0].cyc < cyc) begin
        check("missing_write", cyc, q0[0].cyc);
        void'(q0.pop_front());
      end
      if (WR_FIFO) begin
        if (q0.size() == 0) begin
          check("unexpected_write", {31'd0, WR_FIFO}, 0);
        end else begin
          m0_e = q0.pop_front();
          check("data_out", {24'd0, data_out}, {24'd0, m0_e.ch});
          check("write_cycle", cyc, m0_e.cyc);
          check("busy_while_writing", {31'd0, BUSY}, 1);
          if (m0_e.last) idle_chk0 = cyc + 1;
        end
      end
      if (cyc == idle_chk0) begin
        check("busy_after_lf", {31'd0, BUSY}, 0);
        check("state_idle_after_lf", {29'd0, STATE}, 0);
      end
      if (ovr_q.size() > 0 && ovr_q[0] < cyc) begin
        check("ovr_missing", cyc, ovr_q[0]);
        void'(ovr_q.pop_front());
      end
      if (OVR) begin
        if (ovr_q.size() == 0) check("ovr_unexpected", {31'd0, OVR}, 0);
        else check("ovr_cycle", cyc, ovr_q.pop_front());
      end
    end
  end

  exp_t m1_e;
  always @(negedge CLK) begin
    if (RESET) begin
      if (q1.size() > 0 && q1[0].cyc < cyc) begin
        check("u_missing_write", cyc, q1[0].cyc);
        void'(q1.pop_front());
      end
      if (wr1) begin
        if (q1.size() == 0) begin
          check("u_unexpected_write", {31'd0, wr1}, 0);
        end else begin
          m1_e = q1.pop_front();
          check("u_data_out", {24'd0, dout1}, {24'd0, m1_e.ch});
          check("u_write_cycle", cyc, m1_e.cyc);
          if (m1_e.last) idle_chk1 = cyc + 1;
        end
      end
      if (cyc == idle_chk1) check("u_busy_after_lf", {31'd0, busy1}, 0);
      if (ovr1) check("u_ovr_unexpected", {31'd0, ovr1}, 0);
    end
  end

  task automatic check_regs(input string tag);
    check({tag, "_alu_a"}, {24'd0, ALU_A}, {24'd0, exp_a});
    check({tag, "_alu_b"}, {24'd0, ALU_B}, {24'd0, exp_b});
    check({tag, "_alu_op"}, {24'd0, ALU_OP}, {24'd0, exp_op});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, {29'd0, STATE}, 0);
    check({tag, "_alu_a"}, {24'd0, ALU_A}, 0);
    check({tag, "_alu_b"}, {24'd0, ALU_B}, 0);
    check({tag, "_alu_op"}, {24'd0, ALU_OP}, 32'h20);
    check({tag, "_data_out"}, {24'd0, data_out}, 0);
    check({tag, "_wr_fifo"}, {31'd0, WR_FIFO}, 0);
    check({tag, "_busy"}, {31'd0, BUSY}, 0);
    check({tag, "_ovr"}, {31'd0, OVR}, 0);
  endtask

  // stall: 0 none, 1 random full cycles, 2 full for five cycles from T+3.
  // rst_off >= 0 asserts reset that many cycles after the first write.
  task automatic run_txn(input logic [7:0] v, input int stall, input bit extra, input int rst_off);
    int tc, first, last, x, rst_c;
    repeat ($urandom_range(1, 4)) begin
      @(posedge CLK);
      #1;
      FIN = 1'b0;
      SEL = sels[$urandom_range(0, 4)];
      data_in = 8'($urandom);
      case (SEL)
        3'b001:  exp_a = data_in;
        3'b010:  exp_b = data_in;
        3'b100:  exp_op = data_in;
        default: ;
      endcase
    end
    @(posedge CLK);
    #1;
    SEL = 3'b000;
    FIN = 1'b1;
    alu_res = v;
    tc = cyc;
    for (int c = tc + 3; c <= tc + 40; c++) full_at[c] = 1'b0;
    if (stall == 1) for (int c = tc + 3; c <= tc + 23; c++) full_at[c] = ($urandom_range(0, 2) == 0);
    if (stall == 2) for (int c = tc + 3; c <= tc + 7; c++) full_at[c] = 1'b1;
    push_expect(v, 1'b1, tc, 1'b0, first, last);
    x = extra ? int'($urandom_range(tc + 1, last)) : -1;
    rst_c = (rst_off >= 0) ? first + rst_off : -1;
    @(negedge CLK);
    check_regs("load");
    for (int c = tc + 1; c <= last + 1; c++) begin
      @(posedge CLK);
      #1;
      FIN = (c == x);
      SEL = (c <= last) ? sels[$urandom_range(0, 4)] : 3'b000;
      data_in = 8'($urandom);
      if (c >= tc + 2) alu_res = 8'($urandom);
      if (c == x) ovr_q.push_back(c + 1);
      if (c == rst_c) begin
        #2;
        RESET = 1'b0;
        q0.delete();
        ovr_q.delete();
        idle_chk0 = -1;
        exp_a = 8'h00;
        exp_b = 8'h00;
        exp_op = 8'h20;
        #1;
        check_reset_outputs("rst_mid");
        FIN = 1'b0;
        SEL = 3'b000;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b1;
        repeat (4) begin
          @(negedge CLK);
          check("no_write_after_reset", {31'd0, WR_FIFO}, 0);
          check("idle_after_reset", {31'd0, BUSY}, 0);
        end
        return;
      end
    end
    @(negedge CLK);
    check_regs("hold");
  endtask

  task automatic run_u1(input logic [7:0] v);
    int tc, first, last;
    @(posedge CLK);
    #1;
    SEL = 3'b000;
    FIN1 = 1'b1;
    alu_res = v;
    tc = cyc;
    for (int c = tc + 3; c <= tc + 40; c++) full_at[c] = 1'b0;
    push_expect(v, 1'b0, tc, 1'b1, first, last);
    for (int c = tc + 1; c <= last + 1; c++) begin
      @(posedge CLK);
      #1;
      FIN1 = 1'b0;
      if (c >= tc + 2) alu_res = 8'($urandom);
    end
  endtask

  initial begin
    #2;
    RESET = 1'b0;
    #1;
    check_reset_outputs("rst_init");
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b1;

    run_txn(8'd42, 0, 1'b0, -1);
    run_txn(8'h00, 0, 1'b0, -1);
    run_txn(8'h80, 0, 1'b0, -1);
    run_txn(8'd7, 2, 1'b0, -1);
    run_txn(8'h55, 0, 1'b1, -1);
    run_txn(8'd123, 0, 1'b0, 1);
    run_txn(8'd9, 1, 1'b1, -1);
    repeat (40) run_txn(8'($urandom), int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);

    run_u1(8'hFF);
    run_u1(8'h80);
    run_u1(8'h00);
    repeat (5) run_u1(8'($urandom));

    repeat (10) @(posedge CLK);
    @(negedge CLK);
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    check("ovr_drained", ovr_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
